// File: rtl/bitwise_op_pkg.sv
// Shared opcodes, FSM state encoding and the single-bit logic function
// used by the serial bitwise responder.
package bitwise_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    function automatic logic bit_op(input logic [1:0] op, input logic a, input logic b);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a & b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/bitwise_bit_alu.sv
// Combinational 1-bit logic unit: applies the selected opcode to one bit
// of each operand.
module bitwise_bit_alu
    import bitwise_op_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);

    assign y = bit_op(op, a, b);

endmodule

// File: rtl/bitwise_op_responder.sv
// Serial bitwise-logic responder: accepts two operands and an opcode, builds
// the result one bit per clock LSB first, then holds it until consumed.
module bitwise_op_responder
    import bitwise_op_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic             bit_y;

    assign req_ready = (state == S_IDLE);
    assign rsp_data  = result;

    bitwise_bit_alu u_bit_alu (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .op (op_q),
        .y  (bit_y)
    );

    // Result with the current bit merged in; also feeds the zero flag so it
    // sees the complete word on the final BUSY edge.
    always_comb begin
        // NOTE: assign a default first so no path through this block infers a latch.
        result_next      = result;
        result_next[cnt] = bit_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so rsp_data reads 0 out of reset.
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= OP_AND;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        a_q    <= req_a;
                        b_q    <= req_b;
                        result <= '0;
                        cnt    <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    result <= result_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_zero  <= (result_next == '0);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
